// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// Each frame: pick the pattern bank, snapshot the patterns and blink mask,
// then light each digit for a dwell period followed by an all-off blank gap.
module seg7_scan_ctrl #(
    parameter int P_DIGITS       = 4,
    parameter int P_SEG          = 7,
    parameter int P_DWELL        = 1000,
    parameter int P_BLANK        = 8,
    parameter int P_BLINK_FRAMES = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        src_req,
    input  logic [P_DIGITS*P_SEG-1:0]   seg_in,
    input  logic [P_DIGITS-1:0]         blink_mask,
    output logic                        sel,
    output logic [P_DIGITS-1:0]         an,
    output logic [P_SEG-1:0]            seg_out,
    output logic                        frame_done
);

    localparam int DIG_W   = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
    localparam int CNT_MAX = (P_DWELL > P_BLANK) ? P_DWELL : P_BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FC_W    = $clog2(P_BLINK_FRAMES + 1);

    localparam logic [DIG_W-1:0] LAST_DIG   = DIG_W'(P_DIGITS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(P_DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(P_BLANK - 1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(P_BLINK_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP,
        S_LATCH,
        S_SHOW,
        S_BLANK
    } state_t;

    state_t                      state_q, state_d;
    logic [DIG_W-1:0]            digit_idx_q, digit_idx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FC_W-1:0]             frame_cnt_q, frame_cnt_d;
    logic                        blink_phase_q, blink_phase_d;
    logic [P_DIGITS*P_SEG-1:0]   frame_buf_q, frame_buf_d;
    logic [P_DIGITS-1:0]         mask_buf_q, mask_buf_d;
    logic                        sel_q, sel_d;
    logic [P_DIGITS-1:0]         an_q, an_d;
    logic [P_SEG-1:0]            seg_out_q, seg_out_d;
    logic                        frame_done_q, frame_done_d;

    // Next-state, counters and frame snapshot; frame-level inputs are only
    // looked at in SWAP, LATCH, IDLE and on the last BLANK cycle of a frame.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        digit_idx_d   = digit_idx_q;
        cnt_d         = cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_buf_d   = frame_buf_q;
        mask_buf_d    = mask_buf_q;
        sel_d         = sel_q;

        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_SWAP;
            end
            S_SWAP: begin
                sel_d   = src_req;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                frame_buf_d = seg_in;
                mask_buf_d  = blink_mask;
                digit_idx_d = '0;
                cnt_d       = '0;
                state_d     = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_BLANK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d = '0;
                    if (digit_idx_q == LAST_DIG) begin
                        if (frame_cnt_q == FC_LAST) begin
                            frame_cnt_d   = '0;
                            blink_phase_d = ~blink_phase_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FC_W'(1);
                        end
                        state_d = en ? S_SWAP : S_IDLE;
                    end else begin
                        digit_idx_d = digit_idx_q + DIG_W'(1);
                        state_d     = S_SHOW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so the registered outputs
    // line up exactly with the cycles spent in that state.
    always_comb begin
        an_d      = '0;
        seg_out_d = '0;
        if (state_d == S_SHOW) begin
            for (int d = 0; d < P_DIGITS; d++) begin
                if (digit_idx_d == DIG_W'(d)) begin
                    an_d[d]   = 1'b1;
                    seg_out_d = (mask_buf_d[d] && blink_phase_d) ? '0
                                                                 : frame_buf_d[d*P_SEG +: P_SEG];
                end
            end
        end
        frame_done_d = (state_d == S_BLANK) && (digit_idx_d == LAST_DIG) &&
                       (cnt_d == BLANK_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q       <= S_IDLE;
            digit_idx_q   <= '0;
            cnt_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            // NOTE: the pattern snapshot is cleared too, so a reset display is deterministic.
            frame_buf_q   <= '0;
            mask_buf_q    <= '0;
            sel_q         <= 1'b0;
            an_q          <= '0;
            seg_out_q     <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_idx_q   <= digit_idx_d;
            cnt_q         <= cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_buf_q   <= frame_buf_d;
            mask_buf_q    <= mask_buf_d;
            sel_q         <= sel_d;
            an_q          <= an_d;
            seg_out_q     <= seg_out_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg_out    = seg_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: a frame-position model predicts
// every output each cycle, and directed literal checks pin key moments.
module tb_seg7_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SEG       = 7;
    localparam int DWELL     = 4;
    localparam int BLANK     = 2;
    localparam int BLINK_FR  = 2;
    localparam int SLOT      = DWELL + BLANK;
    localparam int FRAME_LEN = 2 + DIGITS * SLOT;

    localparam logic [DIGITS*SEG-1:0] BANK0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [DIGITS*SEG-1:0] BANK1 = {4{7'h7F}};

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    src_req;
    logic [DIGITS*SEG-1:0]   seg_in;
    logic [DIGITS-1:0]       blink_mask;
    logic                    sel;
    logic [DIGITS-1:0]       an;
    logic [SEG-1:0]          seg_out;
    logic                    frame_done;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl #(
        .P_DIGITS      (DIGITS),
        .P_SEG         (SEG),
        .P_DWELL       (DWELL),
        .P_BLANK       (BLANK),
        .P_BLINK_FRAMES(BLINK_FR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .src_req   (src_req),
        .seg_in    (seg_in),
        .blink_mask(blink_mask),
        .sel       (sel),
        .an        (an),
        .seg_out   (seg_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // External 2:1 pattern muxes driven by the controller's select.
    assign seg_in = sel ? BANK1 : BANK0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame plus the frame-level snapshots.
    bit                    m_active;
    int                    m_pos;
    bit                    m_sel;
    int                    m_frames;
    logic [DIGITS*SEG-1:0] m_buf;
    logic [DIGITS-1:0]     m_mask;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_sel    = 1'b0;
            m_frames = 0;
            m_buf    = '0;
            m_mask   = '0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_pos    = 0;
            end
        end else begin
            if (m_pos == 0) m_sel = src_req;
            if (m_pos == 1) begin
                m_buf  = m_sel ? BANK1 : BANK0;
                m_mask = blink_mask;
            end
            if (m_pos == FRAME_LEN - 1) begin
                m_frames++;
                m_pos    = 0;
                m_active = en;
            end else begin
                m_pos++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [DIGITS-1:0] e_an;
        logic [SEG-1:0]    e_seg;
        logic              e_fd;
        int                k, dig;
        bit                phase;
        e_an  = '0;
        e_seg = '0;
        e_fd  = m_active && (m_pos == FRAME_LEN - 1);
        phase = ((m_frames / BLINK_FR) % 2) == 1;
        if (m_active && m_pos >= 2) begin
            k   = m_pos - 2;
            dig = k / SLOT;
            if ((k % SLOT) < DWELL) begin
                e_an[dig] = 1'b1;
                e_seg     = (m_mask[dig] && phase) ? '0 : m_buf[dig*SEG +: SEG];
            end
        end
        check("model_sel", 32'(sel), 32'(m_sel));
        check("model_an", 32'(an), 32'(e_an));
        check("model_seg", 32'(seg_out), 32'(e_seg));
        check("model_fd", 32'(frame_done), 32'(e_fd));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        src_req    = 1'b0;
        blink_mask = 4'b0010;
        step(2);
        check("rst_an", 32'(an), 32'h0);
        check("rst_seg", 32'(seg_out), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);

        rst = 1'b0;
        step(20);
        check("idle_an", 32'(an), 32'h0);
        check("idle_sel", 32'(sel), 32'h0);

        // Frame 1, bank 0.
        en = 1'b1;
        step(3);
        check("f1_d0_an", 32'(an), 32'h1);
        check("f1_d0_seg", 32'(seg_out), 32'h3F);
        step(6);
        check("f1_d1_an", 32'(an), 32'h2);
        check("f1_d1_seg", 32'(seg_out), 32'h06);
        step(6);
        check("f1_d2_seg", 32'(seg_out), 32'h5B);
        step(6);
        check("f1_d3_an", 32'(an), 32'h8);
        check("f1_d3_seg", 32'(seg_out), 32'h4F);
        step(5);
        check("f1_done", 32'(frame_done), 32'h1);
        check("f1_last_an", 32'(an), 32'h0);
        step(1);
        check("f2_swap_fd", 32'(frame_done), 32'h0);
        check("f2_swap_an", 32'(an), 32'h0);

        // Frame 2: bank request changes mid-frame, no effect yet.
        step(9);
        src_req = 1'b1;
        check("f2_d1_seg", 32'(seg_out), 32'h06);
        step(16);
        check("f2_done", 32'(frame_done), 32'h1);
        step(1);
        check("f3_swap_sel", 32'(sel), 32'h0);
        step(1);
        check("f3_latch_sel", 32'(sel), 32'h1);
        step(1);
        check("f3_d0_seg", 32'(seg_out), 32'h7F);
        step(6);
        check("f3_blink_an", 32'(an), 32'h2);
        check("f3_blink_seg", 32'(seg_out), 32'h00);
        step(17 + 26 + 9);
        check("f5_d1_seg", 32'(seg_out), 32'h7F);

        // Frame 6: drop enable during digit 2.
        step(33);
        check("f6_d2_an", 32'(an), 32'h4);
        en = 1'b0;
        step(10);
        check("f6_done", 32'(frame_done), 32'h1);
        step(1);
        check("stop_an", 32'(an), 32'h0);
        check("stop_fd", 32'(frame_done), 32'h0);
        step(5);
        check("stop_sel_held", 32'(sel), 32'h1);

        // Reset in the middle of digit 1.
        en = 1'b1;
        step(10);
        check("pre_rst_an", 32'(an), 32'h2);
        rst = 1'b1;
        step(1);
        check("mid_rst_an", 32'(an), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_fd", 32'(frame_done), 32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_swap_an", 32'(an), 32'h0);
        step(2);
        check("post_rst_d0_an", 32'(an), 32'h1);
        check("post_rst_d0_seg", 32'(seg_out), 32'h7F);
        step(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
